// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states and port indices for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT, DATA} state_e;
  localparam int NUM_PORTS = 2;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/arb_rr_select.sv
// arb_rr_select: combinational round-robin winner pick with optional owner lock.
module arb_rr_select
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_i,
  input  logic                 lock_i,
  input  logic                 owner_i,
  output logic                 any_o,
  output logic                 winner_o
);
  assign any_o = |req_i;
  always_comb
    winner_o = (lock_i && req_i[owner_i]) ? owner_i :
               (&req_i)                   ? ~last_i :
               (req_i[PORT1] ? PORT1 : PORT0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter onto a single-ported memory, IDLE/GNT/DATA FSM.
// Define MEM_ARB_LOCK_EN to add lock0/lock1 inputs that let the owner keep the next grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);
  state_e                 state_q;
  logic                   owner_q, last_q, lock_q, mem_we_q;
  logic [NUM_PORTS-1:0]   gnt_q, rvalid_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_data_q;
  logic                   any, winner, lock_in;
`ifdef MEM_ARB_LOCK_EN
  assign lock_in = owner_q ? lock1 : lock0;
`else
  assign lock_in = 1'b0;
`endif
  arb_rr_select u_sel (
    .req_i    ({req1, req0}),
    .last_i   (last_q),
    .lock_i   (lock_q),
    .owner_i  (owner_q),
    .any_o    (any),
    .winner_o (winner)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= PORT0;
      last_q     <= PORT1;
      lock_q     <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any) begin
          state_q    <= GNT;
          owner_q    <= winner;
          last_q     <= winner;
          lock_q     <= 1'b0;
          gnt_q      <= winner ? 2'b10 : 2'b01;
          mem_we_q   <= winner ? we1 : we0;
          mem_addr_q <= winner ? addr1 : addr0;
          mem_data_q <= winner ? wdata1 : wdata0;
        end
        GNT: begin
          state_q    <= DATA;
          gnt_q      <= '0;
          rvalid_q   <= mem_we_q ? '0 : gnt_q;
          mem_we_q   <= 1'b0;
          mem_addr_q <= '0;
          mem_data_q <= '0;
        end
        DATA: begin
          state_q  <= IDLE;
          rvalid_q <= '0;
          lock_q   <= lock_in;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign {gnt1, gnt0}     = gnt_q;
  assign {rvalid1, rvalid0} = rvalid_q;
  assign rdata0   = rvalid_q[0] ? mem_in : '0;
  assign rdata1   = rvalid_q[1] ? mem_in : '0;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory model.
module tb_mem_arbiter;
  typedef struct {
    logic        p;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [5:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
`ifdef MEM_ARB_LOCK_EN
  logic        lock0 = 0, lock1 = 0;
`endif
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_data, mem_in;
  logic [5:0]  mem_addr;
  logic [15:0] mem [64];
  exp_t        exp_q[$];
  int          n_cmp = 0, n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({gnt1, gnt0} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {gnt1, gnt0}); end
    n_cmp++; if ({rvalid1, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {rvalid1, rvalid0}); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 6'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    n_cmp++; if (mem_data !== 16'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h want 0000", mem_data); end
    n_cmp++; if ({rdata1, rdata0} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {rdata1, rdata0}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    exp_t e;
    int n = 0;
    exp_q.push_back('{p: 1'b0, we: 1'b0, addr: 6'd5, data: 16'h1234});
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    do begin @(negedge clk); n++; end while (!(gnt0 || gnt1) && n < 8);
    req0 = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL read_latency: got %0d want 1", n); end
    n_cmp++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b want 01", {gnt1, gnt0}); end
    n_cmp++; if (mem_addr !== e.addr || mem_we !== e.we) begin n_fail++; $display("FAIL read_issue: got addr %h we %b want %h %b", mem_addr, mem_we, e.addr, e.we); end
    @(negedge clk);
    n_cmp++; if ({rvalid1, rvalid0} !== 2'b01) begin n_fail++; $display("FAIL read_rvalid: got %b want 01", {rvalid1, rvalid0}); end
    n_cmp++; if (rdata0 !== e.data) begin n_fail++; $display("FAIL read_rdata: got %h want %h", rdata0, e.data); end
    n_cmp++; if (mem_addr !== 6'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL read_data_idle_bus: got addr %h we %b want 00 0", mem_addr, mem_we); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({rvalid1, rvalid0, rdata0} !== 18'h0) begin n_fail++; $display("FAIL read_pulse: got %h want 0", {rvalid1, rvalid0, rdata0}); end
  endtask

  task automatic test_write();
    exp_t e;
    int n = 0;
    exp_q.push_back('{p: 1'b1, we: 1'b1, addr: 6'h3F, data: 16'hBEEF});
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h3F; wdata1 = 16'hBEEF;
    do begin @(negedge clk); n++; end while (!(gnt0 || gnt1) && n < 8);
    req1 = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL write_latency: got %0d want 1", n); end
    n_cmp++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL write_gnt: got %b want 10", {gnt1, gnt0}); end
    n_cmp++; if (mem_we !== e.we || mem_addr !== e.addr || mem_data !== e.data) begin n_fail++; $display("FAIL write_issue: got we %b addr %h data %h want %b %h %h", mem_we, mem_addr, mem_data, e.we, e.addr, e.data); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b0 || {rvalid1, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL write_after_%0d: got we %b rvalid %b want 0 00", c, mem_we, {rvalid1, rvalid0}); end
    end
    n_cmp++; if (mem[6'h3F] !== 16'hBEEF) begin n_fail++; $display("FAIL write_landed: got %h want beef", mem[6'h3F]); end
  endtask

  task automatic test_contention();
    exp_t e;
    int last = -1, got = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{p: i[0], we: 1'b0, addr: 6'd0, data: 16'h0});
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 6'd1; addr1 = 6'd2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt0 && gnt1) begin n_fail++; $display("FAIL contention_mutex: got gnt 11 want one-hot"); end
      if (gnt0 || gnt1) begin
        e = exp_q.pop_front();
        n_cmp++; if (gnt1 !== e.p) begin n_fail++; $display("FAIL contention_order_%0d: got port %b want %b", got, gnt1, e.p); end
        if (last >= 0) begin
          n_cmp++; if (c - last !== 3) begin n_fail++; $display("FAIL contention_spacing_%0d: got %0d want 3", got, c - last); end
        end
        last = c;
        got++;
        if (got == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL contention_count: got %0d want 4", got); end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int last = -1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{p: 1'b1, we: 1'b0, addr: 6'd9, data: 16'h0});
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd9;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_%0d: got %b want 0", c, gnt0); end
      if (gnt1) begin
        n_cmp++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_extra_gnt: got grant at cycle %0d want none", c); end
        else void'(exp_q.pop_front());
        if (last >= 0) begin
          n_cmp++; if (c - last !== 3) begin n_fail++; $display("FAIL single_spacing: got %0d want 3", c - last); end
        end
        last = c;
      end
    end
    req1 = 1'b0;
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL single_count: got %0d missing want 0", exp_q.size()); end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd7; wdata0 = 16'hDEAD;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 8);
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %b want 1", mem_we); end
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || {gnt1, gnt0} !== 2'b00) begin n_fail++; $display("FAIL midrst_drop: got we %b gnt %b want 0 00", mem_we, {gnt1, gnt0}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if ({rvalid1, rvalid0, gnt1, gnt0, mem_we} !== 5'b0) begin n_fail++; $display("FAIL midrst_quiet_%0d: got %b want 00000", c, {rvalid1, rvalid0, gnt1, gnt0, mem_we}); end
    end
    n_cmp++; if (mem[7] !== 16'h0) begin n_fail++; $display("FAIL midrst_abandoned: got %h want 0000", mem[7]); end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    exp_t e;
    int got = 0;
    exp_q.push_back('{p: 1'b0, we: 1'b0, addr: 6'd0, data: 16'h0});
    exp_q.push_back('{p: 1'b0, we: 1'b0, addr: 6'd0, data: 16'h0});
    exp_q.push_back('{p: 1'b1, we: 1'b0, addr: 6'd0, data: 16'h0});
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        e = exp_q.pop_front();
        n_cmp++; if (gnt1 !== e.p) begin n_fail++; $display("FAIL lock_order_%0d: got port %b want %b", got, gnt1, e.p); end
        got++;
        if (got == 2) lock0 = 1'b0;
        if (got == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL lock_count: got %0d want 3", got); end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[5] = 16'h1234;
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_single();
    test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
